mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit with its own controller; owns the HI/LO registers for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Models fixed iterative latency with a busy countdown, and raises a stall request so the hazard unit can hold MDU-dependent instructions.
- Sits beside the ALU in EX. The ALU stays single-cycle.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_calc.sv | 79 +++++++
 rtl/mdu_sequencer.sv | 114 +++++++++++
 tb/tb_mdu_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// state encoding and the predicate that selects the multi-cycle operations.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // MULT, MULTU, DIV and DIVU occupy the unit for several cycles.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath.
// Ports:
//   op       : operation code (mdu_pkg)
//   a, b     : operands (rs, rt)
//   res_hi   : HI result (product high word / remainder)
//   res_lo   : LO result (product low word / quotient)
//   div_zero : divide op with a zero divisor; result must not be written
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   b_safe;
  logic signed [WIDTH-1:0]   a_s;
  logic signed [WIDTH-1:0]   b_s;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   quo_u;
  logic        [WIDTH-1:0]   rem_u;
  logic                      sovf;

  // Sign-extend to full product width so the low 2*WIDTH bits of the
  // multiply are the exact signed product.
  assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign div_zero = is_div_op(op) && (b == '0);

  // Zero divisor and MIN/-1 are replaced by 1 so the dividers never see
  // an undefined case; both outcomes are overridden below anyway.
  assign sovf   = (a == SMIN) && (b == '1);
  assign b_safe = (b == '0) ? WIDTH'(1) : b;
  assign a_s    = a;
  assign b_s    = sovf ? WIDTH'(1) : b_safe;
  assign quo_s  = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quo_u  = a / b_safe;
  assign rem_u  = a % b_safe;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (sovf) begin
          res_hi = '0;
          res_lo = SMIN;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit owning HI/LO for the pipelined core.
// A start op computes its result at once, parks it in pending registers and
// holds busy for a fixed iteration count before committing it to HI/LO.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   op_valid/mdu_op : instruction from EX and its operation code
//   src_a, src_b    : rs / rt operands
//   busy            : operation in flight
//   stall_req       : hold MDU-dependent instructions (incl. the start cycle)
//   hi, lo          : architectural HI/LO registers
//   rd_data         : MFHI/MFLO read value, 0 otherwise
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state;
  mdu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_dz;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             calc_dz;
  logic             start;
  logic             last;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (mdu_op),
    .a        (src_a),
    .b        (src_b),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_dz)
  );

  assign start = (state == ST_IDLE) && op_valid && is_start_op(mdu_op);
  assign last  = (state == ST_RUN) && (cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (start) begin
          cnt <= is_div_op(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (op_valid && (mdu_op == OP_MTHI)) begin
          hi <= src_a;
        end else if (op_valid && (mdu_op == OP_MTLO)) begin
          lo <= src_a;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
        // A zero divisor leaves HI/LO untouched.
        if (last && !pend_dz) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

  // Pending result needs no reset: reset returns to IDLE, so it is never
  // committed.
  always_ff @(posedge clk) begin
    if (start) begin
      pend_hi <= calc_hi;
      pend_lo <= calc_lo;
      pend_dz <= calc_dz;
    end
  end

  assign busy      = (state == ST_RUN);
  assign stall_req = busy || start;

  always_comb begin
    rd_data = '0;
    if (mdu_op == OP_MFHI) rd_data = hi;
    else if (mdu_op == OP_MFLO) rd_data = lo;
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: table of start operations with expected HI/LO
// and busy length, plus hand sequences for MTHI/MTLO, ignored ops while
// busy and reset mid-operation.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int WIDTH = 32;
  localparam int MC    = 5;
  localparam int DC    = 10;

  logic             clk;
  logic             reset;
  logic             op_valid;
  logic [3:0]       mdu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  mdu_sequencer #(.WIDTH(WIDTH), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .mdu_op    (mdu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t         vecs[9];
  logic [63:0]  exp_q[$];
  logic [63:0]  exp_v;
  int           passed;
  int           total;
  int           n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy falls; bounded so a stuck DUT still finishes.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
    if (busy) check("busy_timeout", 64'(busy), 64'(0));
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0;
    mdu_op   = OP_NOP;
    src_a    = '0;
    src_b    = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3] = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[5] = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, DC};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[8] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy",  64'(busy), 64'(0));
    check("reset_stall", 64'(stall_req), 64'(0));
    check("reset_hilo",  {hi, lo}, 64'(0));
    check("rd_nop",      64'(rd_data), 64'(0));

    // Table-driven start operations
    for (int i = 0; i < 9; i++) begin
      op_valid = 1'b1;
      mdu_op   = vecs[i].op;
      src_a    = vecs[i].a;
      src_b    = vecs[i].b;
      #1;
      check($sformatf("stall_start[%0d]", i), 64'(stall_req), 64'(1));
      exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
      tick();
      idle_inputs();
      wait_idle(n);
      check($sformatf("busy_cycles[%0d]", i), 64'(n), 64'(vecs[i].cyc));
      exp_v = exp_q.pop_front();
      check($sformatf("hilo[%0d]", i), {hi, lo}, exp_v);
      mdu_op = OP_MFHI;
      #1;
      check($sformatf("mfhi[%0d]", i), 64'(rd_data), 64'(exp_v[63:32]));
      mdu_op = OP_MFLO;
      #1;
      check($sformatf("mflo[%0d]", i), 64'(rd_data), 64'(exp_v[31:0]));
      idle_inputs();
    end

    // MTHI / MTLO in IDLE
    op_valid = 1'b1;
    mdu_op   = OP_MTHI;
    src_a    = 32'h12345678;
    #1;
    check("mthi_stall", 64'(stall_req), 64'(0));
    tick();
    idle_inputs();
    check("mthi_hi",   64'(hi), 64'(32'h12345678));
    check("mthi_busy", 64'(busy), 64'(0));
    mdu_op = OP_MFHI;
    #1;
    check("mfhi_rd", 64'(rd_data), 64'(32'h12345678));
    op_valid = 1'b1;
    mdu_op   = OP_MTLO;
    src_a    = 32'hCAFEF00D;
    tick();
    idle_inputs();
    check("mtlo_lo", 64'(lo), 64'(32'hCAFEF00D));

    // op_valid low or unknown op code: no effect
    mdu_op = OP_MULT;
    src_a  = 32'd9;
    src_b  = 32'd9;
    #1;
    check("novalid_stall", 64'(stall_req), 64'(0));
    tick();
    check("novalid_busy", 64'(busy), 64'(0));
    op_valid = 1'b1;
    mdu_op   = 4'hF;
    src_a    = 32'h55555555;
    tick();
    idle_inputs();
    check("badop_hilo", {hi, lo}, {32'h12345678, 32'hCAFEF00D});

    // MULT with MTLO and a DIV start issued while busy: both ignored
    op_valid = 1'b1;
    mdu_op   = OP_MULT;
    src_a    = 32'd3;
    src_b    = 32'hFFFFFFFB;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    tick();
    idle_inputs();
    tick();
    op_valid = 1'b1;
    mdu_op   = OP_MTLO;
    src_a    = 32'hDEADBEEF;
    #1;
    check("run_stall", 64'(stall_req), 64'(1));
    tick();
    check("run_lo_stale", 64'(lo), 64'(32'hCAFEF00D));
    mdu_op = OP_DIV;
    src_a  = 32'd100;
    src_b  = 32'd7;
    tick();
    idle_inputs();
    wait_idle(n);
    check("ignored_busy_len", 64'(n), 64'(MC - 3));
    exp_v = exp_q.pop_front();
    check("ignored_hilo", {hi, lo}, exp_v);
    tick();
    check("ignored_no_restart", 64'(busy), 64'(0));

    // Reset in the middle of a divide discards the result
    op_valid = 1'b1;
    mdu_op   = OP_DIV;
    src_a    = 32'd100;
    src_b    = 32'd7;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hilo", {hi, lo}, 64'(0));
    for (int k = 0; k < DC + 2; k++) tick();
    check("rst_no_writeback", {hi, lo}, 64'(0));
    check("rst_still_idle",   64'(busy), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
